// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU instruction sequencer and its decoder.
package alu_seq_pkg;

  localparam int unsigned OPC_W = 5;
  localparam int unsigned CTL_W = 6;

  typedef enum logic [3:0] {
    StIdle,
    StT0,
    StT1,
    StT1W,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsBinary,
    ClsImm,
    ClsMulDiv,
    ClsUnary,
    ClsIllegal
  } opc_class_e;

  localparam logic [OPC_W-1:0] OPC_ADD  = 5'd3;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'd4;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'd5;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'd6;
  localparam logic [OPC_W-1:0] OPC_SHR  = 5'd7;
  localparam logic [OPC_W-1:0] OPC_SHRA = 5'd8;
  localparam logic [OPC_W-1:0] OPC_SHL  = 5'd9;
  localparam logic [OPC_W-1:0] OPC_ROR  = 5'd10;
  localparam logic [OPC_W-1:0] OPC_ROL  = 5'd11;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'd12;
  localparam logic [OPC_W-1:0] OPC_ANDI = 5'd13;
  localparam logic [OPC_W-1:0] OPC_ORI  = 5'd14;
  localparam logic [OPC_W-1:0] OPC_MUL  = 5'd15;
  localparam logic [OPC_W-1:0] OPC_DIV  = 5'd16;
  localparam logic [OPC_W-1:0] OPC_NEG  = 5'd17;
  localparam logic [OPC_W-1:0] OPC_NOT  = 5'd18;

  // Map an opcode onto the step sequence it needs.
  function automatic opc_class_e opc_class(input logic [OPC_W-1:0] opc);
    opc_class_e cls;
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_SHR,
      OPC_SHRA, OPC_SHL, OPC_ROR, OPC_ROL: cls = ClsBinary;
      OPC_ADDI, OPC_ANDI, OPC_ORI:          cls = ClsImm;
      OPC_MUL, OPC_DIV:                     cls = ClsMulDiv;
      OPC_NEG, OPC_NOT:                     cls = ClsUnary;
      default:                              cls = ClsIllegal;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode-class decoder; shared with other instruction sequencers.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output opc_class_e       op_class_o
);

  // Pure table lookup, no state.
  always_comb begin
    op_class_o = opc_class(opcode_i);
  end

endmodule

// File: rtl/alu_seq_ctl.sv
// ALU instruction control sequencer: fetch / operand / execute / writeback steps.
// Optional macro ALU_SEQ_INSTR_CNT_EN adds a 32-bit retired-instruction counter.
module alu_seq_ctl
  import alu_seq_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             run,
  input  logic             mem_ready,
  input  logic [OPC_W-1:0] ir_opcode,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             Cout,
  output logic             Yin,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             LOin,
  output logic             HIin,
  output logic [CTL_W-1:0] ALU_ctl,
  output logic             instr_done,
  output logic             fault
`ifdef ALU_SEQ_INSTR_CNT_EN
  ,
  output logic [31:0]      instr_count
`endif
);

  localparam int unsigned WaitW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

  state_e           state_q;
  logic [WaitW-1:0] wait_q;
  opc_class_e       op_class;
  logic [CTL_W-1:0] exec_ctl;

  alu_seq_decode u_decode (
    .opcode_i   (ir_opcode),
    .op_class_o (op_class)
  );

  assign exec_ctl = {{(CTL_W-OPC_W){1'b0}}, ir_opcode};

  // Step sequencing; run is looked at only in IDLE and in an instruction's final step.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= StIdle;
      wait_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (run) state_q <= StT0;
        StT0:   state_q <= StT1;
        StT1: begin
          wait_q  <= '0;
          state_q <= mem_ready ? StT2 : StT1W;
        end
        StT1W: begin
          if (mem_ready) begin
            state_q <= StT2;
          end else if (wait_q == WaitW'(MEM_WAIT_MAX - 1)) begin
            state_q <= StHalt;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StT2:   state_q <= StT3;
        StT3:   state_q <= (op_class == ClsIllegal) ? StHalt : StT4;
        StT4: begin
          if (op_class == ClsUnary) state_q <= run ? StT0 : StIdle;
          else                      state_q <= StT5;
        end
        StT5: begin
          if (op_class == ClsMulDiv) state_q <= StT6;
          else                       state_q <= run ? StT0 : StIdle;
        end
        StT6:   state_q <= run ? StT0 : StIdle;
        StHalt: state_q <= StHalt;
        default: state_q <= StHalt;
      endcase
    end
  end

  // Moore strobe decode; each state enables at most one bus driver.
  always_comb begin
    PCout      = 1'b0;
    MARin      = 1'b0;
    IncPC      = 1'b0;
    PCin       = 1'b0;
    Read       = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    Cout       = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    LOin       = 1'b0;
    HIin       = 1'b0;
    ALU_ctl    = '0;
    instr_done = 1'b0;
    fault      = 1'b0;
    unique case (state_q)
      StT0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      StT1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      StT1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      StT3: begin
        if (op_class == ClsUnary) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Zin     = 1'b1;
          ALU_ctl = exec_ctl;
        end else if (op_class != ClsIllegal) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end
      end
      StT4: begin
        if (op_class == ClsUnary) begin
          Zlowout    = 1'b1;
          Gra        = 1'b1;
          Rin        = 1'b1;
          instr_done = 1'b1;
        end else if (op_class == ClsImm) begin
          Cout    = 1'b1;
          Zin     = 1'b1;
          ALU_ctl = exec_ctl;
        end else if (op_class != ClsIllegal) begin
          Grc     = 1'b1;
          Rout    = 1'b1;
          Zin     = 1'b1;
          ALU_ctl = exec_ctl;
        end
      end
      StT5: begin
        Zlowout = 1'b1;
        if (op_class == ClsMulDiv) begin
          LOin = 1'b1;
        end else begin
          Gra        = 1'b1;
          Rin        = 1'b1;
          instr_done = 1'b1;
        end
      end
      StT6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      StHalt: fault = 1'b1;
      default: ;
    endcase
  end

`ifdef ALU_SEQ_INSTR_CNT_EN
  logic [31:0] instr_count_q;

  // Retired-instruction count; instr_done never fires in HALT, so HALT freezes it.
  always_ff @(posedge Clock) begin
    if (Reset)           instr_count_q <= '0;
    else if (instr_done) instr_count_q <= instr_count_q + 32'd1;
  end

  assign instr_count = instr_count_q;
`endif

endmodule

// File: doc/alu_seq_ctl.md
Name: alu_seq_ctl

Overview:
- Control sequencer directly upstream of the datapath ALU.
- Steps each instruction through fetch / operand / execute / writeback phases (T0..T6).
- Drives the register-transfer strobes and the 6-bit ALU_ctl that selects the ALU operation.
- Covers register-register, immediate, unary and mul/div ALU instructions; Zhigh/Zlow results are routed to the register file or HI/LO.

Parameters:
- OPC_W, 5, width of IR opcode field IR[31:27].
- CTL_W, 6, width of ALU_ctl.
- MEM_WAIT_MAX, 15, max T1W cycles before the memory-timeout halt.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- run  in  1  level; permits the next fetch.
- mem_ready  in  1  memory read data valid on bus.
- ir_opcode  in  5  IR[31:27]; valid from T3 onward.
- PCout, MARin, IncPC, PCin  out  1 each  PC/MAR strobes.
- Read, MDRin, MDRout, IRin  out  1 each  memory/IR strobes.
- Gra, Grb, Grc, Rin, Rout, Cout  out  1 each  register select / immediate strobes.
- Yin, Zin, Zlowout, Zhighout, LOin, HIin  out  1 each  ALU operand/result strobes.
- ALU_ctl  out  6  operation code to ALU.
- instr_done  out  1  one-cycle pulse in the final step of an instruction.
- fault  out  1  sticky; illegal opcode or memory timeout.

Behaviour:
- Reset (synchronous, active-high): next edge state=IDLE; every output 0, including ALU_ctl=0 and fault=0. Reset wins over all events, including mid-instruction and T1W.
- Opcodes
  - Binary: add 3, sub 4, and 5, or 6, shr 7, shra 8, shl 9, ror 10, rol 11.
  - Immediate: addi 12, andi 13, ori 14.
  - Mul/div: mul 15, div 16.
  - Unary: neg 17, not 18.
  - All others illegal.
- ALU_ctl = {1'b0, ir_opcode} only in the execute step; 0 in all other states.
- IDLE: outputs 0; go T0 when run=1.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin. mem_ready=1 -> T2, else -> T1W.
- T1W: Read and MDRin held. mem_ready=1 -> T2; after MEM_WAIT_MAX cycles -> HALT.
- T2: MDRout, IRin.
- T3:
  - Binary/immediate/muldiv: Grb, Rout, Yin.
  - Unary: Grb, Rout, Zin, ALU_ctl valid (execute step).
  - Illegal opcode -> HALT.
- T4:
  - Binary/muldiv: Grc, Rout, Zin, ALU_ctl valid.
  - Immediate: Cout, Zin, ALU_ctl valid.
  - Unary: Zlowout, Gra, Rin, instr_done.
- T5:
  - Binary/immediate: Zlowout, Gra, Rin, instr_done.
  - Muldiv: Zlowout, LOin.
- T6 (muldiv only): Zhighout, HIin, instr_done.
- After the final step: run=1 -> T0 (no bubble), else -> IDLE. run is sampled only in IDLE and in the final step; deasserting run mid-instruction completes the instruction.
- HALT: all strobes 0, fault=1; exit only by Reset.
- Step lengths: binary/immediate 6 cycles, unary 5, muldiv 7, each plus T1W wait cycles.
- Moore outputs, decoded from registered state and ir_opcode; no strobe glitches.
- At most one of Zlowout/Zhighout/Rout/MDRout/PCout/Cout asserted in any cycle (single bus driver).

Optional Feature:
- Macro: ALU_SEQ_INSTR_CNT_EN.
- Defined: adds output instr_count [31:0].
  - Increments on each instr_done; wraps 0xFFFFFFFF -> 0.
  - Cleared by Reset.
  - Not incremented in HALT.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package alu_seq_pkg:
  - State enum IDLE/T0/T1/T1W/T2/T3/T4/T5/T6/HALT.
  - Opcode constants OPC_ADD..OPC_NOT, CTL_W.
  - Class function returning BINARY/IMM/MULDIV/UNARY/ILLEGAL from opcode.
- One sub-module, alu_seq_decode: combinational opcode-class decoder, reused by the future load/store/branch sequencer.
- The FSM and output decode stay in alu_seq_ctl.

Test Plan:
- Reset, run=1, mem_ready=1, opcode=3 (add) -> T0..T5 in 6 cycles. ALU_ctl=3 only in T4 with Zin=1; Rin+Gra+instr_done in T5; next cycle T0.
- opcode=15 (mul), mem_ready=1 -> LOin+Zlowout in T5, HIin+Zhighout in T6, instr_done in T6 only; total 7 cycles.
- opcode=17 (neg) -> ALU_ctl=17 with Zin in T3, Rin in T4; 5 cycles. opcode=13 (andi) -> Cout+Zin+ALU_ctl=13 in T4.
- mem_ready low 3 cycles after T1 -> 3 T1W cycles with Read=1, then T2; mem_ready never high -> fault=1 after 15 T1W cycles, outputs 0 until Reset.
- opcode=25 (illegal) -> HALT after T3, fault=1 sticky. Reset asserted during T4 of add -> IDLE next edge, all outputs 0, fault cleared.
- With ALU_SEQ_INSTR_CNT_EN: 4 back-to-back adds with run=1 -> instr_count=4; run=0 mid-4th -> completes, count 4, then IDLE.
